// File: rtl/asm_sequencer_if.sv
// Bundle of the sequencer's start/config, memory-read and downstream-control signals.
// master: the sequencer itself; slave: the controller / memories / datapath around it.
interface asm_sequencer_if #(
  parameter int unsigned BN_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned K_WIDTH    = 8
);
  logic                  start;
  logic [K_WIDTH-1:0]    tap_num;
  logic [7:0]            out_num;
  logic [ADDR_WIDTH-1:0] pix_addr;
  logic [ADDR_WIDTH-1:0] weight_addr;
  logic [7:0]            bn_addr;
  logic [1:0]            pix_rdata;
  logic                  weight_rdata;
  logic [BN_WIDTH-1:0]   bn_rdata;
  logic [1:0]            data_pix;
  logic                  data_weight;
  logic [BN_WIDTH-1:0]   data_bn;
  logic                  asm_change;
  logic                  asm_reception;
  logic                  calculate_en;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, tap_num, out_num, pix_rdata, weight_rdata, bn_rdata,
    output pix_addr, weight_addr, bn_addr, data_pix, data_weight, data_bn,
    output asm_change, asm_reception, calculate_en, busy, done
  );

  modport slave (
    output start, tap_num, out_num, pix_rdata, weight_rdata, bn_rdata,
    input  pix_addr, weight_addr, bn_addr, data_pix, data_weight, data_bn,
    input  asm_change, asm_reception, calculate_en, busy, done
  );
endinterface

// File: rtl/asm_sequencer.sv
// Address/control sequencer: streams N neurons x 4 windows x K taps of pixel/weight reads and
// emits control strobes aligned with the 1-cycle-latency read data.
module asm_sequencer #(
  parameter int unsigned BN_WIDTH   = 16,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned K_WIDTH    = 8
) (
  input logic          clk,
  input logic          rst,
  asm_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e                r_state;
  logic [K_WIDTH-1:0]    r_k;
  logic [K_WIDTH-1:0]    r_k_max;
  logic [1:0]            r_w;
  logic [7:0]            r_n;
  logic [7:0]            r_n_last;
  logic [ADDR_WIDTH-1:0] r_wbase;
  logic [ADDR_WIDTH-1:0] r_pix_addr;
  logic [ADDR_WIDTH-1:0] r_weight_addr;
  logic [7:0]            r_bn_addr;
  logic                  r_flush;
  logic                  r_change;
  logic                  r_reception;
  logic                  r_calc;
  logic                  r_busy;
  logic                  r_done;

  logic [K_WIDTH-1:0]    w_k_max_in;
  logic [K_WIDTH:0]      w_k_full;
  logic [ADDR_WIDTH-1:0] w_k_len;
  logic                  w_k_last;
  logic                  w_w_last;
  logic                  w_n_last;
  logic                  w_final;
  logic [BN_WIDTH-1:0]   w_bn;

  // tap_num of zero behaves as a single tap
  assign w_k_max_in = (bus.tap_num == '0) ? '0 : bus.tap_num - 1'b1;
  assign w_k_full   = {1'b0, r_k_max} + {{K_WIDTH{1'b0}}, 1'b1};
  assign w_k_len    = ADDR_WIDTH'(w_k_full);
  assign w_k_last   = (r_k == r_k_max);
  assign w_w_last   = (r_w == 2'd3);
  assign w_n_last   = (r_n == r_n_last);
  assign w_final    = w_k_last && w_w_last && w_n_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StIdle;
      r_k           <= '0;
      r_k_max       <= '0;
      r_w           <= '0;
      r_n           <= '0;
      r_n_last      <= '0;
      r_wbase       <= '0;
      r_pix_addr    <= '0;
      r_weight_addr <= '0;
      r_bn_addr     <= '0;
      r_flush       <= 1'b0;
      r_change      <= 1'b0;
      r_reception   <= 1'b0;
      r_calc        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_change    <= 1'b0;
      r_reception <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_k           <= '0;
            r_w           <= '0;
            r_n           <= '0;
            r_k_max       <= w_k_max_in;
            r_n_last      <= bus.out_num - 8'd1;
            r_wbase       <= '0;
            r_pix_addr    <= '0;
            r_weight_addr <= '0;
            r_bn_addr     <= '0;
            r_flush       <= 1'b0;
            r_busy        <= 1'b1;
            if (bus.out_num != 8'd0) begin
              r_state <= StStream;
              r_calc  <= 1'b1;
            end else begin
              r_state <= StFlush;
            end
          end
        end
        StStream: begin
          // strobes describe the tap whose address is on the bus now; they land with its data
          r_change    <= w_k_last;
          r_reception <= (r_k == '0) && (r_w == 2'd0);
          if (w_final) begin
            r_state <= StFlush;
            r_flush <= 1'b0;
          end else begin
            r_pix_addr <= r_pix_addr + 1'b1;
            if (w_k_last) begin
              r_k <= '0;
              if (w_w_last) begin
                r_w           <= 2'd0;
                r_n           <= r_n + 8'd1;
                r_bn_addr     <= r_n + 8'd1;
                r_wbase       <= r_wbase + w_k_len;
                r_weight_addr <= r_wbase + w_k_len;
              end else begin
                r_w           <= r_w + 2'd1;
                r_weight_addr <= r_wbase;
              end
            end else begin
              r_k           <= r_k + 1'b1;
              r_weight_addr <= r_weight_addr + 1'b1;
            end
          end
        end
        StFlush: begin
          if (!r_flush) begin
            r_flush <= 1'b1;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_calc  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_bn              = bus.bn_rdata;
  assign bus.data_bn       = w_bn;
  assign bus.data_pix      = bus.pix_rdata;
  assign bus.data_weight   = bus.weight_rdata;
  assign bus.pix_addr      = r_pix_addr;
  assign bus.weight_addr   = r_weight_addr;
  assign bus.bn_addr       = r_bn_addr;
  assign bus.asm_change    = r_change;
  assign bus.asm_reception = r_reception;
  assign bus.calculate_en  = r_calc;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_asm_sequencer.sv
// Randomized bench for asm_sequencer; expected per-cycle outputs come from run arithmetic
// (tap index t -> neuron/window/tap) rather than from any state machine.
module tb_asm_sequencer;

  localparam int AW = 10;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  asm_sequencer_if bus ();

  asm_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".pix"},  32'(bus.pix_addr), 0);
    check_val({tag, ".wgt"},  32'(bus.weight_addr), 0);
    check_val({tag, ".bn"},   32'(bus.bn_addr), 0);
    check_val({tag, ".chg"},  32'(bus.asm_change), 0);
    check_val({tag, ".rec"},  32'(bus.asm_reception), 0);
    check_val({tag, ".calc"}, 32'(bus.calculate_en), 0);
    check_val({tag, ".busy"}, 32'(bus.busy), 0);
    check_val({tag, ".done"}, 32'(bus.done), 0);
  endtask

  // Full run from start pulse through the done cycle; ms_cyc >= 1 re-asserts start mid-run.
  task automatic run_seq(input int k_in, input int n_in, input int ms_cyc);
    int k_eff;
    int total;
    int len;
    int t;
    int d;
    k_eff = (k_in == 0) ? 1 : k_in;
    total = 4 * k_eff * n_in;
    len   = total + 2;
    bus.tap_num = 8'(k_in);
    bus.out_num = 8'(n_in);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= len + 1; c++) begin
      t = c - 1;
      d = c - 2;
      if (c <= total) begin
        check_val($sformatf("pix@%0d", c), 32'(bus.pix_addr), t % (1 << AW));
        check_val($sformatf("wgt@%0d", c), 32'(bus.weight_addr),
                  ((t / (4 * k_eff)) * k_eff + t % k_eff) % (1 << AW));
        check_val($sformatf("bn@%0d", c), 32'(bus.bn_addr), t / (4 * k_eff));
      end
      check_val($sformatf("chg@%0d", c), 32'(bus.asm_change),
                (d >= 0 && d < total && (d % k_eff) == k_eff - 1) ? 1 : 0);
      check_val($sformatf("rec@%0d", c), 32'(bus.asm_reception),
                (d >= 0 && d < total && (d % (4 * k_eff)) == 0) ? 1 : 0);
      check_val($sformatf("calc@%0d", c), 32'(bus.calculate_en), (n_in > 0 && c <= len) ? 1 : 0);
      check_val($sformatf("busy@%0d", c), 32'(bus.busy), (c <= len) ? 1 : 0);
      check_val($sformatf("done@%0d", c), 32'(bus.done), (c == len + 1) ? 1 : 0);
      if (c == ms_cyc) begin
        bus.start   = 1'b1;
        bus.tap_num = 8'($urandom_range(0, 255));
        bus.out_num = 8'($urandom_range(0, 255));
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  // Reset asserted in cycle rc of a run: outputs clear at once and no done ever follows.
  task automatic run_abort(input int k_in, input int n_in, input int rc);
    bus.tap_num = 8'(k_in);
    bus.out_num = 8'(n_in);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < rc; c++) tick();
    check_val("abort.busy_before", 32'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val($sformatf("abort.done+%0d", c), 32'(bus.done), 0);
      check_val($sformatf("abort.busy+%0d", c), 32'(bus.busy), 0);
    end
  endtask

  initial begin
    int k_in;
    int n_in;
    int len;
    int ms;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start        = 1'b0;
    bus.tap_num      = '0;
    bus.out_num      = '0;
    bus.pix_rdata    = '0;
    bus.weight_rdata = 1'b0;
    bus.bn_rdata     = '0;
    tick();
    tick();
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      bus.pix_rdata    = 2'($urandom);
      bus.weight_rdata = 1'($urandom);
      bus.bn_rdata     = 16'($urandom);
      #1;
      check_val("pass.pix", 32'(bus.data_pix), 32'(bus.pix_rdata));
      check_val("pass.wgt", 32'(bus.data_weight), 32'(bus.weight_rdata));
      check_val("pass.bn",  32'(bus.data_bn), 32'(bus.bn_rdata));
    end
    tick();

    run_seq(3, 1, -1);
    run_seq(2, 2, -1);
    run_seq(0, 1, -1);
    run_seq(0, 0, -1);
    run_seq(4, 1, 5);
    run_seq(2, 1, 8);
    run_abort(4, 2, 7);
    run_seq(1, 1, -1);
    run_seq(255, 5, 3);
    run_seq(200, 2, -1);

    for (int r = 0; r < 25; r++) begin
      k_in = int'($urandom_range(0, 6));
      n_in = int'($urandom_range(0, 4));
      len  = 4 * ((k_in == 0) ? 1 : k_in) * n_in + 2;
      ms   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, len)) : -1;
      run_seq(k_in, n_in, ms);
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
